// File: rtl/vga_pkg.sv
// vga_pkg -- shared definitions for the VGA raster timing generator.
//   clog2        : ceiling log2 (minimum 1), used to size counters and buses
//   XGA_* / VGA_*: timing constants for the 1024x768@60 and 640x480@60 modes
//   vga_state_t  : enable FSM state encoding
//   sync_t       : {hs, vs, de} bundle carried through the alignment pipe
package vga_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

  // XGA 1024x768 @ 60 Hz
  localparam int XGA_H_DISP  = 1024;
  localparam int XGA_H_FRONT = 24;
  localparam int XGA_H_SYNC  = 136;
  localparam int XGA_H_BACK  = 160;
  localparam int XGA_V_DISP  = 768;
  localparam int XGA_V_FRONT = 3;
  localparam int XGA_V_SYNC  = 6;
  localparam int XGA_V_BACK  = 29;

  // VGA 640x480 @ 60 Hz
  localparam int VGA_H_DISP  = 640;
  localparam int VGA_H_FRONT = 16;
  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_BACK  = 48;
  localparam int VGA_V_DISP  = 480;
  localparam int VGA_V_FRONT = 10;
  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_BACK  = 33;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } vga_state_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if -- pixel request/return bus between the timing generator
// and the pixel source.
//   req_valid/req_x/req_y : request from the generator (master -> slave)
//   pix_data              : pixel returned by the source (slave -> master)
interface vga_timing_gen_if #(
  parameter int XW    = 10,
  parameter int YW    = 10,
  parameter int RGB_W = 12
);
  logic             req_valid;
  logic [XW-1:0]    req_x;
  logic [YW-1:0]    req_y;
  logic [RGB_W-1:0] pix_data;

  modport master (output req_valid, output req_x, output req_y, input pix_data);
  modport slave  (input req_valid, input req_x, input req_y, output pix_data);
endinterface

// File: rtl/vga_delay_pipe.sv
// vga_delay_pipe -- DEPTH-stage shift register with asynchronous clear.
// DEPTH = 0 is a straight pass-through.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset, clears every stage to 0
//   d_i    : WIDTH-bit input
//   q_o    : d_i delayed by DEPTH clocks
module vga_delay_pipe #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign q_o = d_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- parametrised VGA raster timing generator.
//   clk_vga     : pixel clock
//   rst_n       : asynchronous active-low reset
//   en          : run enable, only acted upon at a frame boundary
//   pix_if      : request (x, y, valid) to the pixel source, pixel data back
//   frame_start : pulse at counter state (0,0) while running
//   line_start  : pulse at h_cnt == 0 while running
//   vga_hs/vs   : sync outputs with polarity applied, LAT+1 clocks after counters
//   vga_de      : data enable, aligned with vga_rgb
//   vga_rgb     : pixel colour, 0 outside the active area
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_DISP  = XGA_H_DISP,
  parameter int H_FRONT = XGA_H_FRONT,
  parameter int H_SYNC  = XGA_H_SYNC,
  parameter int H_BACK  = XGA_H_BACK,
  parameter int V_DISP  = XGA_V_DISP,
  parameter int V_FRONT = XGA_V_FRONT,
  parameter int V_SYNC  = XGA_V_SYNC,
  parameter int V_BACK  = XGA_V_BACK,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0,
  parameter int RGB_W   = 12,
  parameter int LAT     = 2
) (
  input  logic             clk_vga,
  input  logic             rst_n,
  input  logic             en,
  vga_timing_gen_if.master pix_if,
  output logic             frame_start,
  output logic             line_start,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_de,
  output logic [RGB_W-1:0] vga_rgb
);

  localparam int H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISP + V_FRONT + V_SYNC + V_BACK;
  // Counters get one spare value so sync-end compares never overflow.
  localparam int HW = clog2(H_TOTAL + 1);
  localparam int VW = clog2(V_TOTAL + 1);
  localparam int XW = clog2(H_DISP);
  localparam int YW = clog2(V_DISP);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_DISP);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_DISP + H_FRONT);
  localparam logic [HW-1:0] HS_END  = HW'(H_DISP + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(V_DISP);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_DISP + V_FRONT);
  localparam logic [VW-1:0] VS_END  = VW'(V_DISP + V_FRONT + V_SYNC);

  vga_state_t       state_q, state_d;
  logic [HW-1:0]    h_q, h_d;
  logic [VW-1:0]    v_q, v_d;
  logic             running, active;
  sync_t            sync_now, sync_dly;
  logic             vga_hs_q, vga_vs_q, vga_de_q;
  logic [RGB_W-1:0] vga_rgb_q;

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  // en only matters at the last pixel of a frame; mid-frame changes are ignored.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    case (state_q)
      ST_IDLE: begin
        h_d = '0;
        v_d = '0;
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (h_q == H_LAST) begin
          h_d = '0;
          if (v_q == V_LAST) begin
            v_d = '0;
            if (!en) state_d = ST_IDLE;
          end else begin
            v_d = v_q + VW'(1);
          end
        end else begin
          h_d = h_q + HW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Everything is gated with running so IDLE (counters parked at 0) looks blank.
  assign running     = (state_q == ST_RUN);
  assign active      = running && (h_q < H_ACT) && (v_q < V_ACT);
  assign sync_now.hs = running && (h_q >= HS_BEG) && (h_q < HS_END);
  assign sync_now.vs = running && (v_q >= VS_BEG) && (v_q < VS_END);
  assign sync_now.de = active;

  assign pix_if.req_valid = active;
  assign pix_if.req_x     = active ? h_q[XW-1:0] : '0;
  assign pix_if.req_y     = active ? v_q[YW-1:0] : '0;
  assign frame_start      = running && (h_q == '0) && (v_q == '0);
  assign line_start       = running && (h_q == '0);

  // Sync bundle waits LAT clocks so it meets the data returned for the same request.
  vga_delay_pipe #(
    .WIDTH ($bits(sync_t)),
    .DEPTH (LAT)
  ) u_sync_pipe (
    .clk_i  (clk_vga),
    .rst_ni (rst_n),
    .d_i    (sync_now),
    .q_o    (sync_dly)
  );

  // Output register: polarity applied here, colour blanked outside active area.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs_q  <= ~HS_POL;
      vga_vs_q  <= ~VS_POL;
      vga_de_q  <= 1'b0;
      vga_rgb_q <= '0;
    end else begin
      vga_hs_q  <= sync_dly.hs ^ ~HS_POL;
      vga_vs_q  <= sync_dly.vs ^ ~VS_POL;
      vga_de_q  <= sync_dly.de;
      vga_rgb_q <= sync_dly.de ? pix_if.pix_data : '0;
    end
  end

  assign vga_hs  = vga_hs_q;
  assign vga_vs  = vga_vs_q;
  assign vga_de  = vga_de_q;
  assign vga_rgb = vga_rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen -- directed bench for vga_timing_gen on a tiny raster
// (H 8/2/3/3, V 4/1/2/1). Two instances share clock, reset and enable:
//   A: active-low syncs, LAT=2, pixel source modelled as a 2-clock delay
//   B: active-high syncs, LAT=0, combinational pixel source
// cyc counts falling edges from the first RUN cycle of instance A/B
// (counter state at cyc c is h = c%16, v = (c/16)%8 while running).
module tb_vga_timing_gen;

  logic clk;
  logic rst_n;
  logic en;

  logic        fs_a, ls_a, hs_a, vs_a, de_a;
  logic [11:0] rgb_a;
  logic        fs_b, ls_b, hs_b, vs_b, de_b;
  logic [11:0] rgb_b;

  int checks;
  int errors;
  int cyc;
  int bad;
  int fs_cnt;

  vga_timing_gen_if #(.XW(3), .YW(2), .RGB_W(12)) ifa ();
  vga_timing_gen_if #(.XW(3), .YW(2), .RGB_W(12)) ifb ();

  vga_timing_gen #(
    .H_DISP(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISP(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .RGB_W(12), .LAT(2)
  ) dut_a (
    .clk_vga(clk), .rst_n(rst_n), .en(en), .pix_if(ifa),
    .frame_start(fs_a), .line_start(ls_a),
    .vga_hs(hs_a), .vga_vs(vs_a), .vga_de(de_a), .vga_rgb(rgb_a)
  );

  vga_timing_gen #(
    .H_DISP(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISP(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .RGB_W(12), .LAT(0)
  ) dut_b (
    .clk_vga(clk), .rst_n(rst_n), .en(en), .pix_if(ifb),
    .frame_start(fs_b), .line_start(ls_b),
    .vga_hs(hs_b), .vga_vs(vs_b), .vga_de(de_b), .vga_rgb(rgb_b)
  );

  function automatic logic [11:0] word(input logic v, input logic [2:0] x, input logic [1:0] y);
    return v ? {2'b00, y, 5'b00000, x} : 12'h000;
  endfunction

  logic [11:0] src_a_d1 = 12'h000;
  logic [11:0] src_a_d2 = 12'h000;
  always @(posedge clk) begin
    src_a_d1 <= word(ifa.req_valid, ifa.req_x, ifa.req_y);
    src_a_d2 <= src_a_d1;
  end
  assign ifa.pix_data = src_a_d2;
  assign ifb.pix_data = word(ifb.req_valid, ifb.req_x, ifb.req_y);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv_to(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; bad = 0; fs_cnt = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_hs_a", 32'(hs_a), 32'd1);
    chk("rst_vs_a", 32'(vs_a), 32'd1);
    chk("rst_de_a", 32'(de_a), 32'd0);
    chk("rst_rgb_a", 32'(rgb_a), 32'd0);
    chk("rst_req_valid", 32'(ifa.req_valid), 32'd0);
    chk("rst_fs_a", 32'(fs_a), 32'd0);
    chk("rst_hs_b", 32'(hs_b), 32'd0);
    chk("rst_vs_b", 32'(vs_b), 32'd0);

    // Idle with en=0: nothing may move
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (hs_a !== 1'b1 || vs_a !== 1'b1 || de_a !== 1'b0 || rgb_a !== 12'h0 ||
          ifa.req_valid !== 1'b0 || hs_b !== 1'b0 || vs_b !== 1'b0) bad++;
      if (fs_a !== 1'b0 || fs_b !== 1'b0) fs_cnt++;
    end
    chk("idle_outputs", 32'(bad), 32'd0);
    chk("idle_frame_start", 32'(fs_cnt), 32'd0);

    // Start: first RUN cycle is cyc 0 at (0,0)
    en  = 1'b1;
    cyc = -1;
    adv_to(0);
    chk("run_fs", 32'(fs_a), 32'd1);
    chk("run_ls", 32'(ls_a), 32'd1);
    chk("run_req_valid", 32'(ifa.req_valid), 32'd1);
    chk("run_req_x0", 32'(ifa.req_x), 32'd0);
    chk("run_req_y0", 32'(ifa.req_y), 32'd0);
    adv_to(1);
    chk("b_de_lat0", 32'(de_b), 32'd1);
    adv_to(2);
    chk("a_de_before", 32'(de_a), 32'd0);
    adv_to(3);
    chk("a_de_first", 32'(de_a), 32'd1);
    adv_to(7);
    chk("req_valid_x7", 32'(ifa.req_valid), 32'd1);
    chk("req_x7", 32'(ifa.req_x), 32'd7);
    adv_to(8);
    chk("req_valid_blank", 32'(ifa.req_valid), 32'd0);
    chk("req_x_blank", 32'(ifa.req_x), 32'd0);
    adv_to(10);
    chk("a_de_last", 32'(de_a), 32'd1);
    chk("b_hs_pre", 32'(hs_b), 32'd0);
    adv_to(11);
    chk("a_de_end", 32'(de_a), 32'd0);
    chk("b_hs_on", 32'(hs_b), 32'd1);
    adv_to(12);
    chk("a_hs_pre", 32'(hs_a), 32'd1);
    adv_to(13);
    chk("a_hs_on", 32'(hs_a), 32'd0);
    adv_to(14);
    chk("b_hs_off", 32'(hs_b), 32'd0);
    adv_to(15);
    chk("a_hs_last", 32'(hs_a), 32'd0);
    adv_to(16);
    chk("a_hs_off", 32'(hs_a), 32'd1);
    chk("ls_line1", 32'(ls_a), 32'd1);
    chk("fs_line1", 32'(fs_a), 32'd0);
    adv_to(17);
    chk("ls_pulse_end", 32'(ls_a), 32'd0);

    // Pixel data alignment
    adv_to(37);
    chk("b_rgb_4_2", 32'(rgb_b), 32'h204);
    adv_to(38);
    chk("b_rgb_5_2", 32'(rgb_b), 32'h205);
    chk("b_de_5_2", 32'(de_b), 32'd1);
    adv_to(40);
    chk("a_rgb_5_2", 32'(rgb_a), 32'h205);
    chk("a_de_5_2", 32'(de_a), 32'd1);
    adv_to(42);
    chk("a_rgb_7_2", 32'(rgb_a), 32'h207);
    adv_to(43);
    chk("a_rgb_blank", 32'(rgb_a), 32'h000);
    chk("a_de_blank", 32'(de_a), 32'd0);

    // Vertical sync: lines 5 and 6
    adv_to(80);
    chk("b_vs_pre", 32'(vs_b), 32'd0);
    adv_to(81);
    chk("b_vs_on", 32'(vs_b), 32'd1);
    adv_to(82);
    chk("a_vs_pre", 32'(vs_a), 32'd1);
    adv_to(83);
    chk("a_vs_on", 32'(vs_a), 32'd0);
    adv_to(114);
    chk("a_vs_last", 32'(vs_a), 32'd0);
    adv_to(115);
    chk("a_vs_off", 32'(vs_a), 32'd1);
    adv_to(127);
    chk("fs_pre_frame2", 32'(fs_a), 32'd0);
    adv_to(128);
    chk("fs_frame2", 32'(fs_a), 32'd1);

    // Drop en at v=1 of frame 2: frame must run to completion
    adv_to(144);
    chk("f2_req_valid_v1", 32'(ifa.req_valid), 32'd1);
    chk("f2_req_y_v1", 32'(ifa.req_y), 32'd1);
    en = 1'b0;
    adv_to(186);
    chk("f2_last_de", 32'(de_a), 32'd1);
    chk("f2_last_rgb", 32'(rgb_a), 32'h307);
    adv_to(187);
    chk("f2_de_end", 32'(de_a), 32'd0);
    adv_to(242);
    chk("f2_vs_full", 32'(vs_a), 32'd0);
    adv_to(243);
    chk("f2_vs_off", 32'(vs_a), 32'd1);
    adv_to(256);
    chk("idle2_fs", 32'(fs_a), 32'd0);
    chk("idle2_ls", 32'(ls_a), 32'd0);
    chk("idle2_req_valid", 32'(ifa.req_valid), 32'd0);
    bad = 0;
    while (cyc < 280) begin
      adv_to(cyc + 1);
      if (fs_a !== 1'b0 || ls_a !== 1'b0 || hs_a !== 1'b1 || vs_a !== 1'b1 ||
          de_a !== 1'b0 || hs_b !== 1'b0 || vs_b !== 1'b0) bad++;
    end
    chk("idle2_quiet", 32'(bad), 32'd0);

    // Restart, then async reset at (6,2)
    en = 1'b1;
    adv_to(281);
    chk("restart_fs", 32'(fs_a), 32'd1);
    chk("restart_req_valid", 32'(ifa.req_valid), 32'd1);
    adv_to(319);
    chk("pre_rst_x", 32'(ifa.req_x), 32'd6);
    chk("pre_rst_y", 32'(ifa.req_y), 32'd2);
    chk("pre_rst_de", 32'(de_a), 32'd1);
    chk("pre_rst_rgb", 32'(rgb_a), 32'h203);
    rst_n = 1'b0;
    #1;
    chk("arst_req_valid", 32'(ifa.req_valid), 32'd0);
    chk("arst_req_x", 32'(ifa.req_x), 32'd0);
    chk("arst_hs_a", 32'(hs_a), 32'd1);
    chk("arst_vs_a", 32'(vs_a), 32'd1);
    chk("arst_de_a", 32'(de_a), 32'd0);
    chk("arst_rgb_a", 32'(rgb_a), 32'd0);
    chk("arst_fs_a", 32'(fs_a), 32'd0);
    chk("arst_ls_a", 32'(ls_a), 32'd0);
    chk("arst_hs_b", 32'(hs_b), 32'd0);
    chk("arst_de_b", 32'(de_b), 32'd0);
    adv_to(320);
    rst_n = 1'b1;
    adv_to(321);
    chk("post_rst_fs", 32'(fs_a), 32'd1);
    chk("post_rst_req_valid", 32'(ifa.req_valid), 32'd1);
    chk("post_rst_fs_b", 32'(fs_b), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
